// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: load funct3 encodings and writeback FSM states.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: picks the byte/halfword/word addressed by
// addr_lo out of a naturally aligned word, extends it, and flags illegal
// or misaligned accesses. Kept standalone so store-side checks can reuse it.
module load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection: byte lane from both address bits, halfword lane from bit 1.
  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
  end

  // Extension and legality by load type; unknown funct3 is treated as illegal.
  always_comb begin
    data       = rdata;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH: begin
        data       = {{(XLEN-16){half_sel[15]}}, half_sel};
        misaligned = addr_lo[0];
      end
      F3_LHU: begin
        data       = {{(XLEN-16){1'b0}}, half_sel};
        misaligned = addr_lo[0];
      end
      F3_LW:   misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: sole driver of the regfile write port. ALU results commit
// one cycle after accept; loads park in WAIT_MEM until the memory response
// arrives, then commit the aligned/extended value.
module writeback_stage
  import riscv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_reg_write,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [1:0]            in_addr_lo,
  input  logic [XLEN-1:0]       in_alu_result,
  input  logic                  mem_rvalid,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] write_register,
  output logic [XLEN-1:0]       write_data,
  output logic                  load_pending,
  output logic [REG_ADDR_W-1:0] load_pending_rd,
  output logic                  misaligned_err
);

  wb_state_t state_reg, state_next;

  // Latched context of the outstanding load.
  logic [REG_ADDR_W-1:0] ld_rd_reg;
  logic                  ld_we_reg;
  logic [2:0]            ld_f3_reg;
  logic [1:0]            ld_addr_reg;

  logic                  reg_write_next;
  logic [REG_ADDR_W-1:0] write_register_next;
  logic [XLEN-1:0]       write_data_next;
  logic                  misaligned_next;
  logic                  latch_load;

  logic                  accept;
  logic [2:0]            align_f3;
  logic [1:0]            align_addr;
  logic [XLEN-1:0]       align_data;
  logic                  align_misaligned;

  assign in_ready        = (state_reg == IDLE);
  assign accept          = in_valid && in_ready;
  assign load_pending    = (state_reg == WAIT_MEM);
  assign load_pending_rd = load_pending ? ld_rd_reg : '0;

  // One aligner serves both phases: in IDLE it vets the incoming load's
  // legality, in WAIT_MEM it extracts from the response using latched context.
  assign align_f3   = (state_reg == IDLE) ? in_funct3  : ld_f3_reg;
  assign align_addr = (state_reg == IDLE) ? in_addr_lo : ld_addr_reg;

  load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .funct3     (align_f3),
    .addr_lo    (align_addr),
    .rdata      (mem_rdata),
    .data       (align_data),
    .misaligned (align_misaligned)
  );

  // Next-state and next-output logic; write index/data hold unless a write fires.
  always_comb begin
    state_next          = state_reg;
    reg_write_next      = 1'b0;
    write_register_next = write_register;
    write_data_next     = write_data;
    misaligned_next     = 1'b0;
    latch_load          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (!in_is_load) begin
            if (in_reg_write && (in_rd != '0)) begin
              reg_write_next      = 1'b1;
              write_register_next = in_rd;
              write_data_next     = in_alu_result;
            end
          end else if (align_misaligned) begin
            misaligned_next = 1'b1;
          end else begin
            latch_load = 1'b1;
            state_next = WAIT_MEM;
          end
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          state_next = IDLE;
          if (ld_we_reg && (ld_rd_reg != '0)) begin
            reg_write_next      = 1'b1;
            write_register_next = ld_rd_reg;
            write_data_next     = align_data;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, output and load-context registers; reset drops any in-flight load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      RegWrite       <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
      misaligned_err <= 1'b0;
      ld_rd_reg      <= '0;
      ld_we_reg      <= 1'b0;
      ld_f3_reg      <= 3'b000;
      ld_addr_reg    <= 2'b00;
    end else begin
      state_reg      <= state_next;
      RegWrite       <= reg_write_next;
      write_register <= write_register_next;
      write_data     <= write_data_next;
      misaligned_err <= misaligned_next;
      if (latch_load) begin
        ld_rd_reg   <= in_rd;
        ld_we_reg   <= in_reg_write;
        ld_f3_reg   <= in_funct3;
        ld_addr_reg <= in_addr_lo;
      end
    end
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage of the RISC-V core and sole driver of the `regfile` write port (`RegWrite`, `write_register`, `write_data`). It accepts completed instructions from the memory stage over a valid/ready handshake. ALU results are committed directly. For loads, the block waits for the data-memory response, then byte/halfword-aligns and sign- or zero-extends the data before committing. It also exports the destination of an outstanding load so decode can stall dependent reads.

## Interface
- `XLEN`, 32, datapath width
- `REG_ADDR_W`, 5, register index width
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  upstream instruction valid
- `in_ready`  out  1  block can accept; combinational, equals (state == IDLE)
- `in_reg_write`  in  1  instruction writes rd
- `in_rd`  in  REG_ADDR_W  destination register
- `in_is_load`  in  1  instruction is a load
- `in_funct3`  in  3  load type (LB/LH/LW/LBU/LHU)
- `in_addr_lo`  in  2  effective address bits [1:0]
- `in_alu_result`  in  XLEN  result for non-load instructions
- `mem_rvalid`  in  1  data-memory read response valid (single-cycle pulse)
- `mem_rdata`  in  XLEN  aligned 32-bit word containing the load target
- `RegWrite`  out  1  registered regfile write enable
- `write_register`  out  REG_ADDR_W  registered regfile write index
- `write_data`  out  XLEN  registered regfile write data
- `load_pending`  out  1  a load is awaiting `mem_rvalid`
- `load_pending_rd`  out  REG_ADDR_W  rd of the pending load; 0 when none pending
- `misaligned_err`  out  1  one-cycle pulse for a rejected load

## Operation
- FSM states: IDLE and WAIT_MEM.
- Accept means `in_valid && in_ready`. This happens only in IDLE.
- **Non-load accepted:**
  - If `in_reg_write` is set and `in_rd != 0`, then `RegWrite <= 1`, `write_register <= in_rd`, `write_data <= in_alu_result`.
  - Otherwise no write is performed.
  - The FSM stays in IDLE.
- **Legal load accepted:** the FSM moves to WAIT_MEM, latching rd, `reg_write`, `funct3` and `addr_lo`.
- **Alignment rules:**
  - LB/LBU: any `addr_lo`.
  - LH/LHU: `addr_lo[0] == 0` required.
  - LW: `addr_lo == 0` required.
  - Any other `funct3` is illegal.
- **Misaligned or illegal load:** `misaligned_err <= 1` for one cycle. No write occurs, the FSM stays in IDLE, and no memory response is awaited.
- **WAIT_MEM with `mem_rvalid`:**
  - The extracted value is written under the same rd≠0 and `reg_write` gating as non-loads.
  - The FSM returns to IDLE.
  - A load to x0 still consumes its response but does not write.
- **Extraction:**
  - LB: `mem_rdata[8*addr_lo +: 8]`, sign-extended. LBU: same byte, zero-extended.
  - LH: `mem_rdata[16*addr_lo[1] +: 16]`, sign-extended. LHU: same halfword, zero-extended.
  - LW: the full word.
- `mem_rvalid` is ignored in IDLE, including in the cycle a load is accepted.
- `RegWrite` and `misaligned_err` default to 0 every cycle unless set as above. `write_register`/`write_data` hold their last value.

## Timing
- **Reset values:**
  - State IDLE.
  - `RegWrite`, `write_register`, `write_data`, `load_pending`, `load_pending_rd`, `misaligned_err` = 0.
  - `in_ready` = 1.
- **Non-load:** accepted in cycle N → `RegWrite` high in N+1 only. Back-to-back accepts give one write per cycle.
- **Load:**
  - Accepted in cycle N → `load_pending` = 1 and `load_pending_rd` = rd from N+1.
  - `mem_rvalid` in cycle M ≥ N+1 → `RegWrite` in M+1.
  - `load_pending` = 0 and `in_ready` = 1 in M+1.
  - The earliest next accept is in M+1.
- **Misaligned load:** accepted in N → `misaligned_err` in N+1 only. `in_ready` never drops.
- **Reset during WAIT_MEM:** immediate return to IDLE with all outputs at reset values. The in-flight load is dropped, and a later `mem_rvalid` is ignored.
- `in_valid` held high while `in_ready` = 0 is not accepted. Upstream holds its inputs stable until the accept.

## Structure
- The shared package `riscv_pkg` holds:
  - funct3 constants `F3_LB`=3'b000, `F3_LH`=3'b001, `F3_LW`=3'b010, `F3_LBU`=3'b100, `F3_LHU`=3'b101.
  - The `wb_state_t` enum {IDLE, WAIT_MEM}.
- One combinational sub-module, `load_align`, maps (`funct3`, `addr_lo`, `rdata`) to (`data`, `misaligned`). It is shared with the future store path checks.
- The top level holds the FSM, the latched load context and the output registers.

## Test plan
- ALU write: accept rd=1, alu=0xBEEFBEEF → next cycle `RegWrite`=1, `write_register`=1, `write_data`=0xBEEFBEEF; 0 the cycle after. Follow with rd=2, alu=0x12345678 the next cycle → consecutive writes.
- x0 and no-write: rd=0, alu=0xFFFFFFFF with `reg_write`=1; rd=3 with `reg_write`=0 → `RegWrite` stays 0 in both cases.
- Byte loads, `mem_rdata`=0x80123456, `addr_lo`=3:
  - LB → 0xFFFFFF80.
  - LBU → 0x00000080.
  - LB with `addr_lo`=0 → 0x00000056.
- Half/word loads, `mem_rdata`=0x80011234:
  - LH `addr_lo`=2 → 0xFFFF8001.
  - LHU `addr_lo`=2 → 0x00008001.
  - LW `addr_lo`=0 → 0x80011234.
- Misaligned: LW `addr_lo`=1 and LH `addr_lo`=3 → `misaligned_err` pulses one cycle each, `RegWrite`=0, `in_ready` stays 1, a stray `mem_rvalid` is ignored.
- Stall and reset:
  - Load rd=5 with `mem_rvalid` 3 cycles late → `in_ready`=0, `load_pending`=1 and `load_pending_rd`=5 for 3 cycles; an ALU op held on `in_valid` is accepted in the write cycle.
  - Repeat with `rst` asserted mid-wait → outputs 0 immediately and the late `mem_rvalid` produces no write.
